// File: rtl/im2col_pkg.sv
// +-----------------------------------------------------------------------------+
// | im2col_pkg : shared FSM state type and geometry helpers for im2col_window_gen |
// | Revision   : 1.0                                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

package im2col_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } im2col_state_t;

  function automatic int out_dim(input int img, input int k, input int stride, input int pad);
    return (img + 2 * pad - k) / stride + 1;
  endfunction

  // Counter width that never collapses to zero bits for a range of n values.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/im2col_line_buf.sv
// +-----------------------------------------------------------------------------+
// | im2col_line_buf : K-1 row RAMs on one column address, taps oldest row first  |
// | Revision        : 1.0                                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module im2col_line_buf
  import im2col_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int K      = 5
) (
  input  logic                      clk,
  input  logic                      wr_en_i,
  input  logic [cnt_w(IMG_W)-1:0]   col_i,
  input  logic [DATA_W-1:0]         data_i,
  output logic [DATA_W-1:0]         taps_o [K-1]
);

  logic [DATA_W-1:0] mem_q [K-1][IMG_W];

  // Each column slot ripples one row older on every write, so the rows never need renaming.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int r = 0; r < K - 2; r++) begin
        mem_q[r][col_i] <= mem_q[r+1][col_i];
      end
      mem_q[K-2][col_i] <= data_i;
    end
  end

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      taps_o[r] = mem_q[r][col_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/im2col_window_gen.sv
// +-----------------------------------------------------------------------------+
// | im2col_window_gen : streams KxK windows from a row-major pixel stream        |
// | Option IM2COL_ZERO_PAD_EN adds an implicit (K-1)/2 zero border.              |
// | Revision          : 1.0                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module im2col_window_gen
  import im2col_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [DATA_W-1:0]          pix_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [DATA_W-1:0]          win [K*K],
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
);

`ifdef IM2COL_ZERO_PAD_EN
  localparam int C_PAD = (K - 1) / 2;
`else
  localparam int C_PAD = 0;
`endif
  localparam int C_PW = IMG_W + 2 * C_PAD;
  localparam int C_PH = IMG_H + 2 * C_PAD;
  localparam int C_CW = cnt_w(C_PW);
  localparam int C_RW = cnt_w(C_PH);
  localparam int C_SW = cnt_w(STRIDE);

  localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(C_PW - 1);
  localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(C_PH - 1);
  localparam logic [C_CW-1:0] C_COL_KM1  = C_CW'(K - 1);
  localparam logic [C_RW-1:0] C_ROW_KM1  = C_RW'(K - 1);
  localparam logic [C_SW-1:0] C_SM1      = C_SW'(STRIDE - 1);

  im2col_state_t state_q, state_d;

  logic [C_CW-1:0]            col_q;
  logic [C_RW-1:0]            row_q;
  logic [C_SW-1:0]            scol_q, srow_q;
  logic [$clog2(IMG_W)-1:0]   ocol_q, win_col_q;
  logic [$clog2(IMG_H)-1:0]   orow_q, win_row_q;
  logic                       win_valid_q, win_valid_d;
  logic [DATA_W-1:0]          sr_q [K*K];

  logic [DATA_W-1:0]          taps [K-1];
  logic [DATA_W-1:0]          new_col [K];
  logic                       room, pad_slot, adv, emit, last_pix;
  logic                       col_hit, row_hit, frame_start;
  logic [DATA_W-1:0]          pix_eff;

`ifdef IM2COL_ZERO_PAD_EN
  localparam logic [C_CW-1:0] C_COL_P   = C_CW'(C_PAD);
  localparam logic [C_RW-1:0] C_ROW_P   = C_RW'(C_PAD);
  localparam logic [C_CW-1:0] C_COL_END = C_CW'(IMG_W + C_PAD);
  localparam logic [C_RW-1:0] C_ROW_END = C_RW'(IMG_H + C_PAD);
  assign pad_slot = (col_q < C_COL_P) || (col_q >= C_COL_END) ||
                    (row_q < C_ROW_P) || (row_q >= C_ROW_END);
`else
  assign pad_slot = 1'b0;
`endif

  assign room        = !win_valid_q || win_ready;
  assign pix_ready   = (state_q == RUN) && room && !pad_slot;
  assign adv         = (state_q == RUN) && room && (pad_slot || pix_valid);
  assign pix_eff     = pad_slot ? '0 : pix_data;
  assign col_hit     = (col_q >= C_COL_KM1) && (scol_q == '0);
  assign row_hit     = (row_q >= C_ROW_KM1) && (srow_q == '0);
  assign emit        = adv && col_hit && row_hit;
  assign last_pix    = adv && (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);
  assign win_valid_d = emit || (win_valid_q && !win_ready);
  assign frame_start = (state_q == IDLE) && start;

  im2col_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (C_PW),
    .K      (K)
  ) u_line_buf (
    .clk     (clk),
    .wr_en_i (adv),
    .col_i   (col_q),
    .data_i  (pix_eff),
    .taps_o  (taps)
  );

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = taps[r];
    end
    new_col[K-1] = pix_eff;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pix) state_d = win_valid_d ? DRAIN : DONE;
      DRAIN:   if (win_valid_q && win_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      scol_q      <= '0;
      srow_q      <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      for (int e = 0; e < K * K; e++) sr_q[e] <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      if (frame_start) begin
        col_q  <= '0;
        row_q  <= '0;
        scol_q <= '0;
        srow_q <= '0;
        ocol_q <= '0;
        orow_q <= '0;
      end else if (adv) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) sr_q[r*K+c] <= sr_q[r*K+c+1];
          sr_q[r*K+K-1] <= new_col[r];
        end
        if (emit) begin
          win_row_q <= orow_q;
          win_col_q <= ocol_q;
        end
        // Stride phases are down-counters that restart at zero at the first legal index.
        if (col_q == C_COL_LAST) begin
          col_q  <= '0;
          scol_q <= '0;
          ocol_q <= '0;
          row_q  <= row_q + 1'b1;
          if (row_q >= C_ROW_KM1) begin
            srow_q <= (srow_q == '0) ? C_SM1 : srow_q - 1'b1;
            if (srow_q == '0) orow_q <= orow_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
          if (col_q >= C_COL_KM1) begin
            scol_q <= (scol_q == '0) ? C_SM1 : scol_q - 1'b1;
            if (scol_q == '0) ocol_q <= ocol_q + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int e = 0; e < K * K; e++) win[e] = sr_q[e];
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_im2col_window_gen.sv
// +-----------------------------------------------------------------------------+
// | tb_im2col_window_gen : random-handshake bench, stride 1 and stride 2 DUTs    |
// | Revision             : 1.0                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_im2col_window_gen;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 5;
  localparam int KK     = K * K;
  localparam int N      = IMG_W * IMG_H;
  localparam int BUDGET = 20000;
`ifdef IM2COL_ZERO_PAD_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] img [N];
  int errors = 0;
  int checks = 0;
  int n_acc [2];
  int n_win [2];
  int done_cnt [2];
  int hold_cnt [2];
  bit hold_req [2];

  logic                      pv [2];
  logic                      pr [2];
  logic [DATA_W-1:0]         pd [2];
  logic                      wv [2];
  logic                      wrdy [2];
  logic [$clog2(IMG_H)-1:0]  wrow [2];
  logic [$clog2(IMG_W)-1:0]  wcol [2];
  logic                      bz [2];
  logic                      dn [2];
  logic [DATA_W-1:0]         win0 [2];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference window element straight from image coordinates.
  function automatic logic [DATA_W-1:0] exp_el(input int s, input int w, input int e);
    int ow, orow, ocol, y, x;
    ow   = (IMG_W + 2 * P - K) / s + 1;
    orow = w / ow;
    ocol = w % ow;
    y    = orow * s + e / K - P;
    x    = ocol * s + e % K - P;
    if (y < 0 || y >= IMG_H || x < 0 || x >= IMG_W) return '0;
    return img[y * IMG_W + x];
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int S   = (i == 0) ? 1 : 2;
    localparam int OW  = (IMG_W + 2 * P - K) / S + 1;
    localparam int OH  = (IMG_H + 2 * P - K) / S + 1;
    localparam int TOT = OW * OH;

    logic [DATA_W-1:0] win_l [KK];
    assign win0[i] = win_l[0];

    im2col_window_gen #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .K      (K),
      .STRIDE (S)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pix_valid (pv[i]),
      .pix_ready (pr[i]),
      .pix_data  (pd[i]),
      .win_valid (wv[i]),
      .win_ready (wrdy[i]),
      .win       (win_l),
      .win_row   (wrow[i]),
      .win_col   (wcol[i]),
      .busy      (bz[i]),
      .done      (dn[i])
    );

    initial begin
      pv[i]   = 1'b0;
      pd[i]   = '0;
      wrdy[i] = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        pv[i] = (n_acc[i] < N) && ($urandom_range(0, 3) != 0);
        pd[i] = img[(n_acc[i] < N) ? n_acc[i] : N - 1];
        if (hold_cnt[i] > 0) begin
          wrdy[i] = 1'b0;
          hold_cnt[i]--;
        end else begin
          wrdy[i] = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        if (wv[i]) begin
          if (hold_req[i]) begin
            hold_req[i] = 1'b0;
            hold_cnt[i] = 10;
          end
          if (n_win[i] < TOT) begin
            int idx;
            idx = 0;
            for (int e = 0; e < KK; e++) begin
              if (win_l[e] !== exp_el(S, n_win[i], e)) begin
                idx = e;
                break;
              end
            end
            chk($sformatf("win_data s%0d w%0d e%0d", S, n_win[i], idx),
                win_l[idx], exp_el(S, n_win[i], idx));
            chk("win_row", wrow[i], n_win[i] / OW);
            chk("win_col", wcol[i], n_win[i] % OW);
          end else begin
            chk("win_extra", n_win[i] + 1, TOT);
          end
          if (!wrdy[i]) chk("bp_pix_ready", pr[i], 0);
          else n_win[i]++;
        end
        if (pv[i] && pr[i]) n_acc[i]++;
        if (dn[i]) begin
          done_cnt[i]++;
          chk("done_after_last", n_win[i], TOT);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_win_valid"}, wv[i], 0);
      chk({tag, "_pix_ready"}, pr[i], 0);
      chk({tag, "_busy"}, bz[i], 0);
      chk({tag, "_done"}, dn[i], 0);
      chk({tag, "_win_row"}, wrow[i], 0);
      chk({tag, "_win_col"}, wcol[i], 0);
      chk({tag, "_win0"}, win0[i], 0);
    end
  endtask

  task automatic run_frame(input bit poke_start, input bit abort);
    int  cyc;
    bit  poked;
    for (int i = 0; i < 2; i++) begin
      n_acc[i]    = 0;
      n_win[i]    = 0;
      done_cnt[i] = 0;
    end
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("busy_after_start", bz[0], 1);
    cyc   = 0;
    poked = 1'b0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && cyc < BUDGET) begin
      @(posedge clk); #2;
      cyc++;
      if (poke_start && !poked && n_acc[0] >= 200) begin
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        poked = 1'b1;
      end
      if (abort && n_acc[0] >= 300) begin
        rst = 1'b1;
        #1;
        check_idle("midrst");
        chk("midrst_no_done0", done_cnt[0], 0);
        chk("midrst_no_done1", done_cnt[1], 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        return;
      end
    end
    chk("frame_timeout", (cyc < BUDGET) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("done_pulses_s1", done_cnt[0], 1);
    chk("done_pulses_s2", done_cnt[1], 1);
    chk("win_total_s1", n_win[0], ((IMG_W + 2 * P - K) / 1 + 1) * ((IMG_H + 2 * P - K) / 1 + 1));
    chk("win_total_s2", n_win[1], ((IMG_W + 2 * P - K) / 2 + 1) * ((IMG_H + 2 * P - K) / 2 + 1));
    chk("pix_total_s1", n_acc[0], N);
    chk("pix_total_s2", n_acc[1], N);
    chk("idle_busy", bz[0], 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_acc[i]    = 0;
      n_win[i]    = 0;
      done_cnt[i] = 0;
      hold_cnt[i] = 0;
      hold_req[i] = 1'b0;
    end
    for (int p = 0; p < N; p++) img[p] = DATA_W'(p);
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    rst = 1'b0;

    // Frame 1: ramp image, forced backpressure on the first window, stray start mid-frame.
    hold_req[0] = 1'b1;
    run_frame(1'b1, 1'b0);

    // Frame 2: random image, aborted by reset after 300 pixels.
    for (int p = 0; p < N; p++) img[p] = DATA_W'($urandom);
    run_frame(1'b0, 1'b1);

    // Frame 3: fresh random image after the abort.
    for (int p = 0; p < N; p++) img[p] = DATA_W'($urandom);
    run_frame(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/im2col_window_gen.md
Name: im2col_window_gen

Overview:
- Parametrised successor to the fixed 28-wide, 5x5 img2col mapper.
- Accepts a row-major pixel stream over a valid/ready handshake and buffers K-1 image rows in line buffers.
- Emits one KxK window vector per output position, with configurable stride and output backpressure.
- Feeds the weight-stationary MAC array. Each window is K*K words, matching the weight vector length.

Parameters:
- DATA_W, 16, pixel width in bits
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, kernel side; window holds K*K words (legal 2..IMG_W)
- STRIDE, 1, window step in both directions (legal 1..K)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  input pixel accepted when pix_valid && pix_ready
- pix_data  in  DATA_W  pixel value
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts the window
- win  out  DATA_W x K*K (unpacked)  win[r*K+c] = pixel(top+r, left+c); win[0] is top-left
- win_row  out  $clog2(IMG_H)  output-row index of the current window
- win_col  out  $clog2(IMG_W)  output-column index of the current window
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last window handshake of a frame

Behaviour:
- Reset values: all outputs 0; state IDLE; row/column counters 0. Line buffer RAM is not cleared (contents are masked until valid).
- Output geometry: OUT_W = (IMG_W-K)/STRIDE+1, OUT_H = (IMG_H-K)/STRIDE+1, using integer division.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the last pixel (IMG_H-1, IMG_W-1) is accepted while its window is still pending.
  - DRAIN -> DONE when that window handshakes.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
  - If the last window handshakes in the same cycle the last pixel is accepted, RUN -> DONE directly.
- Input acceptance: pix_ready = (state==RUN) && (!win_valid || win_ready). This ensures a new window can never overwrite an unaccepted one.
- Per accepted pixel:
  - Shift the window columns left by one.
  - Load the new right column from the K-1 line-buffer taps plus pix_data.
  - Write pix_data into the line buffer at column col.
  - Advance col; wrap to 0 at IMG_W-1 and increment row.
- Window emit condition: the accepted pixel at (row, col) satisfies row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
- Latency: win_valid rises on the cycle after the completing pixel is accepted.
- While win_valid=1: win, win_row and win_col are held stable until the handshake. On the handshake cycle, win_valid drops unless the same cycle's accepted pixel produces a new window, in which case valid stays high with new data.
- Stride modulo: implemented with down-counters reloaded to STRIDE-1, not a divider.
- Row-wrap windows: the shift register carries stale columns across row boundaries; windows with col<K-1 are never emitted, so this needs no special handling.
- start asserted while busy: ignored; counters are not disturbed.
- rst mid-frame: immediate return to IDLE, all counters cleared, no done pulse. The next start begins a fresh frame.
- pix_valid in IDLE/DRAIN/DONE: not accepted (pix_ready=0).

Optional Feature:
- Macro: IM2COL_ZERO_PAD_EN.
- Defined:
  - Implicit zero border of P=(K-1)/2 on all sides; OUT_W = (IMG_W+2P-K)/STRIDE+1, OUT_H likewise.
  - The generator inserts pad pixels of value 0 internally, holding pix_ready=0 in pad slots, so the input stream is still exactly IMG_W*IMG_H pixels.
  - Internal row/column counters span IMG_W+2P by IMG_H+2P.
  - The last-pixel condition refers to the last padded position.
- Undefined: no padding logic; geometry as above.

Decomposition:
- Package im2col_pkg holds:
  - typedef enum {IDLE, RUN, DRAIN, DONE} im2col_state_t
  - function out_dim(img, k, stride, pad)
  - localparam helpers for counter widths.
- Sub-module im2col_line_buf(DATA_W, IMG_W, K):
  - K-1 row RAMs sharing one column address.
  - Taps read combinationally at col.
  - Write enabled by pixel accept.
  - Tap order: oldest row first.

Test Plan:
- Basic geometry: IMG 28x28, K=5, S=1, pix_data = row*28+col, win_ready=1 -> first window follows acceptance of pixel 116 with win[0]=0, win[4]=4, win[20]=112, win[24]=116, win_row=win_col=0. Exactly 576 windows, last window win[24]=783, then done pulses once.
- Stride: K=5, S=2 -> 144 windows; second window win[0]=2, win_col=1; first window of output row 1 has win[0]=56.
- Backpressure: hold win_ready=0 for 10 cycles after the first win_valid -> win stable, pix_ready=0, no pixel lost; window count still 576 and data matches the golden model.
- Reset mid-operation: assert rst after 300 accepted pixels -> outputs 0 next edge, no done; restart the full frame -> 576 correct windows.
- Start while busy: pulse start mid-frame -> ignored, sequence identical to the clean run.
- Padding (IM2COL_ZERO_PAD_EN, K=5, S=1): 28x28 -> 784 windows; first window has win[12]=0 (pixel 0), win[13]=1, win[18]=29, win[0..11]=0 (pad); exactly 784 pixels accepted.
